clk_pll_rst_ctrl: RTL and testbench
===================================

// Module: clk_pll_rst_ctrl
// PURPOSE
//  Drives the clk_pll reset input and consumes its locked output. Runs on the free-running 50 MHz refclk.
//  Pulses the PLL reset and qualifies lock (synchroniser, stability window, timeout, auto re-lock).
//  Releases sys_rst to the 20/80 MHz baseband domains only once lock is stable.
//  Per-domain reset synchronisers sit downstream of sys_rst and are not part of this block.
// PARAMETERS
//  PLL_RST_CYCLES      16      refclk cycles pll_rst is held high per reset attempt (>=2)
//  LOCK_STABLE_CYCLES  1024    consecutive synced-locked cycles required before release (>=2)
//  LOCK_TIMEOUT_CYCLES 500000  max cycles in WAIT before retry (10 ms @ 50 MHz)
//  LOSS_FILTER_CYCLES  4       consecutive unlocked cycles that count as loss of lock (filter build only)
//  CNT_W               20      counter width; must hold LOCK_TIMEOUT_CYCLES-1
// PORTS
//  refclk      in   1  reference clock, 50 MHz, free-running
//  rst         in   1  async active-high reset
//  locked      in   1  PLL locked, asynchronous to refclk
//  pll_rst     out  1  reset to PLL, active-high
//  sys_rst     out  1  reset to downstream domains, active-high
//  ready       out  1  lock qualified, sys_rst released
//  relock_cnt  out  8  count of lock losses in RUN, saturates at 255
//  timeout_err out  1  sticky: at least one WAIT timeout has occurred
// BEHAVIOUR
//  - Clock and reset: one clock (refclk); reset is asynchronous, active-high (rst).
//  - Reset values: state=S_PLLRST, counters=0, pll_rst=1, sys_rst=1, ready=0, relock_cnt=0, timeout_err=0.
//  - Synchroniser: locked passes through a 2-flop synchroniser to give lock_s (2-cycle latency).
//  - Registered outputs: all outputs are registered and decoded from next-state, so they change in the same cycle as the state.
//  - S_PLLRST: pll_rst=1, sys_rst=1, ready=0.
//      Counts 0..PLL_RST_CYCLES-1, then goes to S_WAIT with counters cleared.
//      pll_rst is high exactly PLL_RST_CYCLES cycles per attempt.
//  - S_WAIT: pll_rst=0, sys_rst=1.
//      stable_cnt increments while lock_s=1 and clears to 0 when lock_s=0.
//      tmo_cnt increments every cycle.
//      stable_cnt==LOCK_STABLE_CYCLES-1 with lock_s=1 -> S_RUN.
//      Otherwise tmo_cnt==LOCK_TIMEOUT_CYCLES-1 -> S_PLLRST and timeout_err<=1.
//      If both occur in the same cycle, lock wins.
//  - S_RUN: sys_rst=0, ready=1, pll_rst=0.
//      A loss of lock -> S_PLLRST, with relock_cnt+1 (saturating).
//      sys_rst=1 and ready=0 on the cycle of the transition.
//  - Retries: re-lock after a timeout is unlimited; timeout_err stays set until rst.
//  - Reset mid-operation: rst at any time returns all outputs to reset values asynchronously.
//      The sequence restarts from S_PLLRST on rst release.
//  - lock_s dropping in WAIT restarts the stability window but not the timeout.
// CONFIGURATION
//  CLK_PLL_LOSS_FILTER_EN defined:
//      loss = lock_s low for LOSS_FILTER_CYCLES consecutive cycles in S_RUN.
//      Shorter dropouts are ignored, the filter count clears when lock_s=1, and relock_cnt is unchanged.
//  CLK_PLL_LOSS_FILTER_EN undefined:
//      loss = any single cycle of lock_s=0 in S_RUN; no filter counter is built.
// TESTING  (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, LOSS_FILTER_CYCLES=3)
//  1. Release rst, raise locked at cycle 10 and hold it
//      -> pll_rst high cycles 0-3
//      -> ready=1 and sys_rst=0 exactly 2+8 cycles after locked rises; relock_cnt=0.
//  2. locked held 0 -> pll_rst pulses 4 cycles every 4+64 cycles; timeout_err=1 after the first timeout;
//      sys_rst stays 1.
//  3. In RUN, drop locked for 1 cycle
//      -> filter build: no state change, relock_cnt=0
//      -> no-filter build: relock_cnt=1, new 4-cycle pll_rst pulse.
//  4. In RUN, drop locked for 5 cycles -> both builds: sys_rst=1, pll_rst pulse, relock_cnt=1;
//      ready returns after lock re-qualifies.
//  5. In WAIT, lock toggles 1 for 5 cycles, 0 for 1 cycle, then stays 1
//      -> release 8 synced cycles after the final rise.
//  6. Assert rst mid-WAIT and mid-RUN -> outputs return to reset values immediately;
//      force 300 losses -> relock_cnt=255.

Source files
------------

// File: rtl/clk_pll_rst_ctrl.sv
// clk_pll_rst_ctrl: sequences the clk_pll reset, qualifies its lock indication and
// releases sys_rst to the baseband domains once lock has been stable long enough.
// Runs entirely on refclk.
// Build option: define CLK_PLL_LOSS_FILTER_EN to require LOSS_FILTER_CYCLES consecutive
// unlocked cycles in RUN before treating it as a loss of lock; otherwise any single
// unlocked cycle counts.
module clk_pll_rst_ctrl #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned LOSS_FILTER_CYCLES  = 4,
    parameter int unsigned CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] relock_cnt,
    output logic       timeout_err
);

    // Reject configurations the counters cannot represent.
    if (PLL_RST_CYCLES < 2 || LOCK_STABLE_CYCLES < 2 || LOCK_TIMEOUT_CYCLES < 2 ||
        LOSS_FILTER_CYCLES < 1 ||
        longint'(LOCK_TIMEOUT_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_param_err
        $error("clk_pll_rst_ctrl: invalid parameter set");
    end

    localparam logic [CNT_W-1:0] RstLast    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TmoLast    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StPllRst,
        StWait,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic              lock_meta, lock_s;
    logic [CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]        relock_cnt_d;
    logic              timeout_err_d;
    logic              loss;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_s    <= lock_meta;
        end
    end

`ifdef CLK_PLL_LOSS_FILTER_EN
    localparam logic [CNT_W-1:0] LossLast = CNT_W'(LOSS_FILTER_CYCLES - 1);

    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Counts consecutive unlocked cycles in RUN; clears on any locked cycle or state exit.
    always_comb begin
        loss_cnt_d = '0;
        loss       = 1'b0;
        if (state_q == StRun && !lock_s) begin
            if (loss_cnt_q == LossLast) begin
                loss = 1'b1;
            end else begin
                loss_cnt_d = loss_cnt_q + CNT_W'(1);
            end
        end
    end

    // Loss filter counter register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end
`else
    // Any unlocked cycle in RUN is a loss of lock.
    always_comb begin
        loss = (state_q == StRun) && !lock_s;
    end
`endif

    // Next-state, counter and status logic.
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        stable_cnt_d  = stable_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        relock_cnt_d  = relock_cnt;
        timeout_err_d = timeout_err;
        unique case (state_q)
            StPllRst: begin
                if (rst_cnt_q == RstLast) begin
                    state_d      = StWait;
                    rst_cnt_d    = '0;
                    stable_cnt_d = '0;
                    tmo_cnt_d    = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + CNT_W'(1);
                end
            end
            StWait: begin
                // Lock qualification takes priority over a coincident timeout.
                if (lock_s && stable_cnt_q == StableLast) begin
                    state_d      = StRun;
                    stable_cnt_d = '0;
                    tmo_cnt_d    = '0;
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d       = StPllRst;
                    timeout_err_d = 1'b1;
                    stable_cnt_d  = '0;
                    tmo_cnt_d     = '0;
                end else begin
                    tmo_cnt_d    = tmo_cnt_q + CNT_W'(1);
                    stable_cnt_d = lock_s ? stable_cnt_q + CNT_W'(1) : '0;
                end
            end
            StRun: begin
                if (loss) begin
                    state_d = StPllRst;
                    if (relock_cnt != 8'hFF) begin
                        relock_cnt_d = relock_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StPllRst;
            end
        endcase
    end

    // State, counters and outputs; outputs decode next state so they move with the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= StPllRst;
            rst_cnt_q    <= '0;
            stable_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            relock_cnt   <= 8'd0;
            timeout_err  <= 1'b0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            relock_cnt   <= relock_cnt_d;
            timeout_err  <= timeout_err_d;
            pll_rst      <= (state_d == StPllRst);
            sys_rst      <= (state_d != StRun);
            ready        <= (state_d == StRun);
        end
    end

endmodule

// File: tb/tb_clk_pll_rst_ctrl.sv
// Bench for clk_pll_rst_ctrl: segment table of {locked, expected outputs} plus a
// long relock loop for relock_cnt saturation. Expected values go through a scoreboard queue.
module tb_clk_pll_rst_ctrl;

    localparam int ST_P = 0;  // PLL reset: pll_rst=1 sys_rst=1 ready=0
    localparam int ST_W = 1;  // waiting:   pll_rst=0 sys_rst=1 ready=0
    localparam int ST_R = 2;  // running:   pll_rst=0 sys_rst=0 ready=1

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready, timeout_err;
    logic [7:0] relock_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         do_rst;
        int         n;
        logic       lk;
        int         st;
        logic       te;
        logic [7:0] rc;
        string      name;
    } seg_t;

    typedef struct {
        logic [11:0] v;
        string       name;
    } exp_t;

    seg_t vec[$];
    exp_t exp_q[$];

    clk_pll_rst_ctrl #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (64),
        .LOSS_FILTER_CYCLES  (3),
        .CNT_W               (20)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .relock_cnt  (relock_cnt),
        .timeout_err (timeout_err)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic seg_t mk(bit r, int n, logic lk, int st, logic te, logic [7:0] rc,
                                string nm);
        seg_t s;
        s.do_rst = r;
        s.n      = n;
        s.lk     = lk;
        s.st     = st;
        s.te     = te;
        s.rc     = rc;
        s.name   = nm;
        return s;
    endfunction

    function automatic logic [11:0] pack_exp(int st, logic te, logic [7:0] rc);
        logic [2:0] o;
        case (st)
            ST_P:    o = 3'b110;
            ST_W:    o = 3'b010;
            default: o = 3'b001;
        endcase
        return {o, te, rc};
    endfunction

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got pll_rst,sys_rst,ready,timeout_err=%b relock_cnt=%0d; want %b relock_cnt=%0d",
                     nm, got[11:8], got[7:0], want[11:8], want[7:0]);
        end
    endtask

    function automatic logic [11:0] outs();
        return {pll_rst, sys_rst, ready, timeout_err, relock_cnt};
    endfunction

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got %b, want an entry", outs());
        end else begin
            e = exp_q.pop_front();
            chk(e.name, outs(), e.v);
        end
    endtask

    // One refclk cycle: locked applied before the edge, outputs sampled on the falling edge.
    task automatic step(input logic lk, input logic [11:0] v, input string nm);
        locked = lk;
        exp_q.push_back('{v, nm});
        @(posedge refclk);
        @(negedge refclk);
        check_pop();
    endtask

    // Asynchronous reset: check outputs before any clock edge, then release on a falling edge.
    task automatic apply_reset(input string nm);
        rst    = 1'b1;
        locked = 1'b0;
        #1;
        exp_q.push_back('{pack_exp(ST_P, 1'b0, 8'd0), {nm, "_async"}});
        check_pop();
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        exp_q.push_back('{pack_exp(ST_P, 1'b0, 8'd0), {nm, "_release"}});
        check_pop();
    endtask

    task automatic idle(input logic lk, input int n);
        locked = lk;
        repeat (n) @(posedge refclk);
        @(negedge refclk);
    endtask

    initial begin
        // Lock rises at cycle 10, release at cycle 20.
        vec.push_back(mk(1, 3, 0, ST_P, 0, 0, "t1_pllrst"));
        vec.push_back(mk(0, 7, 0, ST_W, 0, 0, "t1_wait"));
        vec.push_back(mk(0, 9, 1, ST_W, 0, 0, "t1_qualify"));
        vec.push_back(mk(0, 10, 1, ST_R, 0, 0, "t1_run"));
`ifdef CLK_PLL_LOSS_FILTER_EN
        vec.push_back(mk(0, 1, 0, ST_R, 0, 0, "t3_drop"));
        vec.push_back(mk(0, 15, 1, ST_R, 0, 0, "t3_ignored"));
        vec.push_back(mk(0, 4, 0, ST_R, 0, 0, "t4_filtering"));
        vec.push_back(mk(0, 1, 0, ST_P, 0, 1, "t4_pllrst_lo"));
        vec.push_back(mk(0, 3, 1, ST_P, 0, 1, "t4_pllrst_hi"));
        vec.push_back(mk(0, 8, 1, ST_W, 0, 1, "t4_wait"));
        vec.push_back(mk(0, 5, 1, ST_R, 0, 1, "t4_run"));
`else
        vec.push_back(mk(0, 1, 0, ST_R, 0, 0, "t3_drop"));
        vec.push_back(mk(0, 1, 1, ST_R, 0, 0, "t3_sync_lag"));
        vec.push_back(mk(0, 4, 1, ST_P, 0, 1, "t3_pllrst"));
        vec.push_back(mk(0, 8, 1, ST_W, 0, 1, "t3_wait"));
        vec.push_back(mk(0, 3, 1, ST_R, 0, 1, "t3_run"));
        vec.push_back(mk(0, 2, 0, ST_R, 0, 1, "t4_sync_lag"));
        vec.push_back(mk(0, 3, 0, ST_P, 0, 2, "t4_pllrst_lo"));
        vec.push_back(mk(0, 1, 1, ST_P, 0, 2, "t4_pllrst_hi"));
        vec.push_back(mk(0, 8, 1, ST_W, 0, 2, "t4_wait"));
        vec.push_back(mk(0, 5, 1, ST_R, 0, 2, "t4_run"));
`endif
        // Reset from RUN, then repeated timeouts with locked held low.
        vec.push_back(mk(1, 3, 0, ST_P, 0, 0, "t2_pllrst1"));
        vec.push_back(mk(0, 64, 0, ST_W, 0, 0, "t2_wait1"));
        vec.push_back(mk(0, 4, 0, ST_P, 1, 0, "t2_pllrst2"));
        vec.push_back(mk(0, 64, 0, ST_W, 1, 0, "t2_wait2"));
        vec.push_back(mk(0, 4, 0, ST_P, 1, 0, "t2_pllrst3"));
        vec.push_back(mk(0, 30, 0, ST_W, 1, 0, "t2_wait3"));
        // Reset mid-WAIT; lock qualifies on the very cycle the timeout expires.
        vec.push_back(mk(1, 3, 0, ST_P, 0, 0, "tie_pllrst"));
        vec.push_back(mk(0, 55, 0, ST_W, 0, 0, "tie_wait"));
        vec.push_back(mk(0, 9, 1, ST_W, 0, 0, "tie_qualify"));
        vec.push_back(mk(0, 3, 1, ST_R, 0, 0, "tie_lock_wins"));
        // Reset mid-RUN; a glitch in WAIT restarts the stability window.
        vec.push_back(mk(1, 3, 0, ST_P, 0, 0, "t5_pllrst"));
        vec.push_back(mk(0, 7, 0, ST_W, 0, 0, "t5_wait"));
        vec.push_back(mk(0, 5, 1, ST_W, 0, 0, "t5_hi1"));
        vec.push_back(mk(0, 1, 0, ST_W, 0, 0, "t5_glitch"));
        vec.push_back(mk(0, 9, 1, ST_W, 0, 0, "t5_hi2"));
        vec.push_back(mk(0, 3, 1, ST_R, 0, 0, "t5_run"));

        @(negedge refclk);
        foreach (vec[i]) begin
            if (vec[i].do_rst) apply_reset(vec[i].name);
            for (int k = 0; k < vec[i].n; k++) begin
                step(vec[i].lk, pack_exp(vec[i].st, vec[i].te, vec[i].rc), vec[i].name);
            end
        end

        // 300 lock losses from RUN; relock_cnt must stop at 255.
        for (int i = 0; i < 300; i++) begin
            idle(1'b0, 5);
            idle(1'b1, 20);
            chk("sat_relocked", {pll_rst, sys_rst, ready, timeout_err, 8'd0},
                {pack_exp(ST_R, 1'b0, 8'd0)});
            if (i == 253) chk("sat_254", {4'd0, relock_cnt}, {4'd0, 8'd254});
            if (i == 254) chk("sat_255", {4'd0, relock_cnt}, {4'd0, 8'd255});
        end
        chk("sat_final", outs(), pack_exp(ST_R, 1'b0, 8'd255));

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
